multi_field_setter: RTL and testbench

//  Generalised time/date setting FSM for the clock display path; sits between the debounced key block and
//  the BCD time counter. Edits NUM_FIELDS two-digit BCD fields, each with its own [min,max] range, with

---
 rtl/multi_field_setter_if.sv | 32 +++
 rtl/multi_field_setter.sv | 167 ++++++++++++++++
 tb/tb_multi_field_setter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multi_field_setter_if.sv
// multi_field_setter_if: key/value bus between the key block, the field setter and the counter.
//   master : drives set_p/sel_p/cancel_p pulses, inc_btn/dec_btn levels and the live cur_val;
//            observes set_en/set_load/set_val/edit_idx/blink_en/timeout_p.
//   slave  : the setter itself (mirror directions).
interface multi_field_setter_if #(
  parameter int NUM_FIELDS = 3
);
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic                    set_p;
  logic                    sel_p;
  logic                    cancel_p;
  logic                    inc_btn;
  logic                    dec_btn;
  logic [8*NUM_FIELDS-1:0] cur_val;
  logic                    set_en;
  logic                    set_load;
  logic [8*NUM_FIELDS-1:0] set_val;
  logic [IW-1:0]           edit_idx;
  logic                    blink_en;
  logic                    timeout_p;

  modport master (
    output set_p, sel_p, cancel_p, inc_btn, dec_btn, cur_val,
    input  set_en, set_load, set_val, edit_idx, blink_en, timeout_p
  );

  modport slave (
    input  set_p, sel_p, cancel_p, inc_btn, dec_btn, cur_val,
    output set_en, set_load, set_val, edit_idx, blink_en, timeout_p
  );
endinterface

// File: rtl/multi_field_setter.sv
// multi_field_setter: two-state (IDLE/EDIT) editor for NUM_FIELDS two-digit BCD fields.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of multi_field_setter_if
//              in : set_p (enter/commit), sel_p (next field), cancel_p (abort),
//                   inc_btn/dec_btn (held key levels), cur_val (live counter value)
//              out: set_en/blink_en (editing), set_load (commit pulse), set_val (edited value),
//                   edit_idx (field under edit), timeout_p (inactivity abort pulse)
// Each field wraps within its own [FIELD_MIN, FIELD_MAX]; held keys auto-repeat after
// REPEAT_DLY cycles, then every REPEAT_PER cycles. All outputs are registered.
module multi_field_setter #(
  parameter int                      NUM_FIELDS  = 3,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN   = {8'h00, 8'h00, 8'h00},
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX   = {8'h23, 8'h59, 8'h59},
  parameter logic [8*NUM_FIELDS-1:0] RESET_VAL   = {8'h12, 8'h00, 8'h00},
  parameter logic [15:0]             REPEAT_DLY  = 16'd500,
  parameter logic [15:0]             REPEAT_PER  = 16'd100,
  parameter logic [31:0]             TIMEOUT_CYC = 32'd10000
) (
  input logic                clk,
  input logic                rst,
  multi_field_setter_if.slave bus
);
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int W  = 8 * NUM_FIELDS;

  typedef enum logic {IDLE, EDIT} state_t;

  state_t        state;
  logic [W-1:0]  set_val_q;
  logic [IW-1:0] edit_idx_q;
  logic          set_en_q, set_load_q, timeout_q;
  logic          inc_prev, dec_prev;   // raw key levels last cycle
  logic          inc_lock, dec_lock;   // key was held on entry; ignored until released
  logic [15:0]   rpt_cnt;              // cycles since edge / since last repeat step
  logic          rpt_ph;               // 0: waiting for first repeat, 1: periodic repeats
  logic [31:0]   to_cnt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                         input logic [7:0] mx);
    if (v == mx)              return mn;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                         input logic [7:0] mx);
    if (v == mn)              return mx;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return v - 8'd1;
  endfunction

  // Key qualification: a key counts only if unlocked and the other key is not down.
  logic act_inc, act_dec, key, key_prev, key_edge, rpt_hit, step, activity, to_expire;

  always_comb begin
    act_inc   = bus.inc_btn & ~inc_lock & ~bus.dec_btn;
    act_dec   = bus.dec_btn & ~dec_lock & ~bus.inc_btn;
    key       = act_inc | act_dec;
    key_prev  = act_inc ? inc_prev : dec_prev;
    key_edge  = key & ~key_prev;
    rpt_hit   = key & key_prev &
                (rpt_ph ? (rpt_cnt == REPEAT_PER) : (rpt_cnt == REPEAT_DLY - 16'd1));
    step      = key_edge | rpt_hit;
    activity  = bus.cancel_p | bus.set_p | bus.sel_p | step | bus.inc_btn | bus.dec_btn;
    to_expire = ~activity & (to_cnt == TIMEOUT_CYC - 32'd1);
  end

  // Per-field entry clamp and stepped value.
  logic [W-1:0] clamped, stepped;

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fld
    localparam logic [7:0] FMIN = FIELD_MIN[8*g +: 8];
    localparam logic [7:0] FMAX = FIELD_MAX[8*g +: 8];
    logic [7:0] cv, v;
    logic       ok, sel_me;
    assign cv     = bus.cur_val[8*g +: 8];
    assign v      = set_val_q[8*g +: 8];
    assign ok     = (cv[7:4] <= 4'd9) && (cv[3:0] <= 4'd9) && (cv >= FMIN) && (cv <= FMAX);
    assign sel_me = (edit_idx_q == IW'(g));
    assign clamped[8*g +: 8] = ok ? cv : FMIN;
    assign stepped[8*g +: 8] = !sel_me ? v :
                               act_inc ? bcd_inc(v, FMIN, FMAX) : bcd_dec(v, FMIN, FMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      set_val_q  <= RESET_VAL;
      edit_idx_q <= IW'(NUM_FIELDS - 1);
      set_en_q   <= 1'b0;
      set_load_q <= 1'b0;
      timeout_q  <= 1'b0;
      inc_prev   <= 1'b0;
      dec_prev   <= 1'b0;
      inc_lock   <= 1'b0;
      dec_lock   <= 1'b0;
      rpt_cnt    <= '0;
      rpt_ph     <= 1'b0;
      to_cnt     <= '0;
    end else begin
      set_load_q <= 1'b0;
      timeout_q  <= 1'b0;
      inc_prev   <= bus.inc_btn;
      dec_prev   <= bus.dec_btn;
      case (state)
        IDLE: begin
          rpt_cnt <= '0;
          rpt_ph  <= 1'b0;
          to_cnt  <= '0;
          if (bus.set_p) begin
            state      <= EDIT;
            set_en_q   <= 1'b1;
            set_val_q  <= clamped;
            edit_idx_q <= IW'(NUM_FIELDS - 1);
            inc_lock   <= bus.inc_btn;
            dec_lock   <= bus.dec_btn;
          end
        end
        EDIT: begin
          if (!bus.inc_btn) inc_lock <= 1'b0;
          if (!bus.dec_btn) dec_lock <= 1'b0;

          if (bus.cancel_p) begin
            state    <= IDLE;
            set_en_q <= 1'b0;
          end else if (bus.set_p) begin
            state      <= IDLE;
            set_en_q   <= 1'b0;
            set_load_q <= 1'b1;
          end else if (to_expire) begin
            state     <= IDLE;
            set_en_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else if (bus.sel_p) begin
            edit_idx_q <= (edit_idx_q == '0) ? IW'(NUM_FIELDS - 1) : edit_idx_q - IW'(1);
          end else if (step) begin
            set_val_q <= stepped;
          end

          // Repeat timing restarts on a new edge, and after a select (step dropped).
          if (bus.sel_p || !key) begin
            rpt_cnt <= '0;
            rpt_ph  <= 1'b0;
          end else if (key_edge) begin
            rpt_cnt <= 16'd1;
            rpt_ph  <= 1'b0;
          end else if (rpt_hit) begin
            rpt_cnt <= 16'd1;
            rpt_ph  <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 16'd1;
          end

          to_cnt <= activity ? '0 : to_cnt + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.set_en    = set_en_q;
  assign bus.blink_en  = set_en_q;
  assign bus.set_load  = set_load_q;
  assign bus.timeout_p = timeout_q;
  assign bus.set_val   = set_val_q;
  assign bus.edit_idx  = edit_idx_q;
endmodule

// File: tb/tb_multi_field_setter.sv
module tb_multi_field_setter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_field_setter_if #(.NUM_FIELDS(3)) bus();
  multi_field_setter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int load_cnt = 0;

  always @(posedge clk) if (bus.set_load === 1'b1) load_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_set();
    bus.set_p = 1'b1; tick(); bus.set_p = 1'b0;
  endtask
  task automatic pulse_sel();
    bus.sel_p = 1'b1; tick(); bus.sel_p = 1'b0;
  endtask
  task automatic pulse_cancel();
    bus.cancel_p = 1'b1; tick(); bus.cancel_p = 1'b0;
  endtask
  task automatic press_inc();
    bus.inc_btn = 1'b1; tick(); bus.inc_btn = 1'b0; tick();
  endtask
  task automatic press_dec();
    bus.dec_btn = 1'b1; tick(); bus.dec_btn = 1'b0; tick();
  endtask

  logic [23:0] prev;
  int          nchg;
  int          got [8];
  int          tms [7] = '{1, 500, 600, 700, 800, 900, 1000};

  initial begin
    rst = 1'b1;
    bus.set_p = 1'b0; bus.sel_p = 1'b0; bus.cancel_p = 1'b0;
    bus.inc_btn = 1'b0; bus.dec_btn = 1'b0; bus.cur_val = 24'h000000;
    tick(); tick();
    chk("rst_set_val",  bus.set_val,   24'h120000);
    chk("rst_idx",      bus.edit_idx,  2);
    chk("rst_set_en",   bus.set_en,    0);
    chk("rst_blink",    bus.blink_en,  0);
    chk("rst_load",     bus.set_load,  0);
    chk("rst_timeout",  bus.timeout_p, 0);
    rst = 1'b0;
    tick();

    // 1: enter and commit unchanged
    bus.cur_val = 24'h235958;
    pulse_set();
    chk("t1_set_en",  bus.set_en,   1);
    chk("t1_blink",   bus.blink_en, 1);
    chk("t1_val",     bus.set_val,  24'h235958);
    chk("t1_idx",     bus.edit_idx, 2);
    pulse_set();
    chk("t1_load",    bus.set_load, 1);
    chk("t1_en_off",  bus.set_en,   0);
    chk("t1_val_ld",  bus.set_val,  24'h235958);
    tick();
    chk("t1_load_1cy", bus.set_load, 0);
    chk("t1_load_cnt", load_cnt,     1);

    // 2: inc/dec wrap on hours, select, BCD carry on seconds
    bus.cur_val = 24'h235909;
    pulse_set();
    chk("t2_entry", bus.set_val, 24'h235909);
    press_inc();
    chk("t2_inc_wrap", bus.set_val, 24'h005909);
    press_dec();
    chk("t2_dec_wrap", bus.set_val, 24'h235909);
    pulse_sel();
    chk("t2_sel1", bus.edit_idx, 1);
    pulse_sel();
    chk("t2_sel0", bus.edit_idx, 0);
    press_inc();
    chk("t2_inc_carry", bus.set_val, 24'h235910);
    press_dec();
    chk("t2_dec_borrow", bus.set_val, 24'h235909);

    // 3: auto-repeat while held 1000 cycles
    prev = bus.set_val;
    nchg = 0;
    for (int i = 0; i < 8; i++) got[i] = 0;
    bus.inc_btn = 1'b1;
    for (int t = 1; t <= 1000; t++) begin
      tick();
      if (bus.set_val !== prev) begin
        if (nchg < 8) got[nchg] = t;
        nchg++;
        prev = bus.set_val;
      end
    end
    bus.inc_btn = 1'b0;
    tick();
    chk("t3_steps", nchg, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("t3_time%0d", i), got[i], tms[i]);
    chk("t3_val", bus.set_val, 24'h235916);
    chk("t3_still_edit", bus.set_en, 1);

    // step coinciding with sel_p is dropped; sel wraps 0 -> 2
    bus.sel_p = 1'b1; bus.inc_btn = 1'b1;
    tick();
    bus.sel_p = 1'b0;
    chk("sel_wrap", bus.edit_idx, 2);
    chk("sel_drop_step", bus.set_val, 24'h235916);
    bus.inc_btn = 1'b0;
    tick();
    chk("sel_drop_after", bus.set_val, 24'h235916);
    pulse_cancel();
    chk("cancel_en", bus.set_en, 0);
    chk("cancel_keep", bus.set_val, 24'h235916);
    tick();
    chk("cancel_noload", load_cnt, 1);

    // key held on entry: no step until re-pressed
    bus.cur_val = 24'h101010;
    bus.inc_btn = 1'b1;
    pulse_set();
    repeat (600) tick();
    chk("held_entry_nostep", bus.set_val, 24'h101010);
    bus.inc_btn = 1'b0;
    tick();
    press_inc();
    chk("held_entry_repress", bus.set_val, 24'h111010);
    pulse_cancel();

    // 4: clamp of invalid / out-of-range fields, cancel without load
    bus.cur_val = 24'h2A7799;
    pulse_set();
    chk("t4_clamp", bus.set_val, 24'h000000);
    press_inc();
    chk("t4_inc", bus.set_val, 24'h010000);
    pulse_cancel();
    chk("t4_cancel_en", bus.set_en, 0);
    tick();
    chk("t4_noload", load_cnt, 1);

    // commit in the cycle the timeout would fire: commit wins
    bus.cur_val = 24'h010203;
    pulse_set();
    repeat (9999) tick();
    chk("ct_before", bus.set_en, 1);
    pulse_set();
    chk("ct_load", bus.set_load, 1);
    chk("ct_no_timeout", bus.timeout_p, 0);
    tick();
    chk("ct_load_cnt", load_cnt, 2);

    // 5: inactivity timeout
    bus.cur_val = 24'h040506;
    pulse_set();
    repeat (9999) tick();
    chk("t5_pre_en", bus.set_en, 1);
    chk("t5_pre_to", bus.timeout_p, 0);
    tick();
    chk("t5_to_pulse", bus.timeout_p, 1);
    chk("t5_en_off", bus.set_en, 0);
    chk("t5_no_load", bus.set_load, 0);
    tick();
    chk("t5_to_1cy", bus.timeout_p, 0);
    chk("t5_load_cnt", load_cnt, 2);

    // 6: async reset mid-edit
    bus.cur_val = 24'h123456;
    pulse_set();
    press_inc();
    chk("t6_edit", bus.set_val, 24'h133456);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_val", bus.set_val, 24'h120000);
    chk("t6_rst_en", bus.set_en, 0);
    chk("t6_rst_idx", bus.edit_idx, 2);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_load", load_cnt, 2);
    chk("t6_idle", bus.set_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
